conv_kernel_mc: RTL and testbench

Parametrised multi-channel integer convolution kernel. Each accepted beat carries one KSIZE×KSIZE input window and one weight window per output channel. The block forms N_CH signed dot products, accumulates them over a group of beats (input channels) marked by first/last flags, and emits one post-processed result per output channel: arithmetic shift, optional ReLU, saturation. It sits between the line-buffer/window generator and the ofmap writer, with valid/ready handshakes on both sides and full backpressure.

---
 rtl/conv_kernel_mc.sv | 128 ++++++++++++
 tb/tb_conv_kernel_mc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_mc.sv
// ============================================================================
// conv_kernel_mc : multi-channel KxK signed dot-product accumulator with
//                  shift / ReLU / saturation post-processing.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module conv_kernel_mc #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  parameter int N_CH   = 2,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_first,
  input  logic                                 in_last,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]        ifmap,
  input  logic [N_CH*KSIZE*KSIZE*DATA_W-1:0]   weight,
  input  logic                                 cfg_relu,
  input  logic [4:0]                           cfg_shift,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N_CH*OUT_W-1:0]                ofmap,
  output logic [N_CH-1:0]                      out_ovf
);

  localparam int KK = KSIZE * KSIZE;
  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    w_en;
  logic signed [PW-1:0]    w_prod [N_CH*KK];
  logic signed [PW-1:0]    r_prod [N_CH*KK];
  logic                    r_s1_valid;
  logic                    r_s1_first;
  logic                    r_s1_last;
  logic signed [ACC_W-1:0] r_acc      [N_CH];
  logic signed [ACC_W-1:0] w_sum      [N_CH];
  logic signed [ACC_W-1:0] w_acc_next [N_CH];
  logic signed [ACC_W-1:0] w_shifted  [N_CH];
  logic [OUT_W-1:0]        w_res      [N_CH];
  logic [N_CH-1:0]         w_ovf;
  logic                    w_load;
  logic                    r_out_valid;
  logic [N_CH*OUT_W-1:0]   r_ofmap;
  logic [N_CH-1:0]         r_ovf;

  // The whole pipeline stalls only when a result is held and not consumed.
  assign w_en      = !(r_out_valid && !out_ready);
  assign in_ready  = w_en;
  assign w_load    = r_s1_valid && r_s1_last;
  assign out_valid = r_out_valid;
  assign ofmap     = r_ofmap;
  assign out_ovf   = r_ovf;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar i = 0; i < KK; i++) begin : g_el
      assign w_prod[c*KK+i] = $signed(ifmap[i*DATA_W +: DATA_W])
                            * $signed(weight[(c*KK+i)*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int j = 0; j < N_CH*KK; j++) r_prod[j] <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
      for (int j = 0; j < N_CH*KK; j++) r_prod[j] <= w_prod[j];
    end
  end

  always_comb begin
    w_ovf = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_sum[c] = '0;
      for (int i = 0; i < KK; i++)
        w_sum[c] = w_sum[c] + {{(ACC_W-PW){r_prod[c*KK+i][PW-1]}}, r_prod[c*KK+i]};
      w_acc_next[c] = (r_s1_first ? '0 : r_acc[c]) + w_sum[c];
      w_shifted[c]  = w_acc_next[c] >>> cfg_shift;
      if (cfg_relu && w_shifted[c][ACC_W-1]) w_shifted[c] = '0;
      if (w_shifted[c] > c_sat_max) begin
        w_res[c] = c_sat_max[OUT_W-1:0];
        w_ovf[c] = 1'b1;
      end else if (w_shifted[c] < c_sat_min) begin
        w_res[c] = c_sat_min[OUT_W-1:0];
        w_ovf[c] = 1'b1;
      end else begin
        w_res[c] = w_shifted[c][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) r_acc[c] <= '0;
    end else if (w_en && r_s1_valid) begin
      for (int c = 0; c < N_CH; c++) r_acc[c] <= r_s1_last ? '0 : w_acc_next[c];
    end
  end

  // Output register only changes when not stalled, so held data stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ofmap     <= '0;
      r_ovf       <= '0;
    end else if (w_en) begin
      r_out_valid <= w_load;
      if (w_load) begin
        for (int c = 0; c < N_CH; c++) r_ofmap[c*OUT_W +: OUT_W] <= w_res[c];
        r_ovf <= w_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_kernel_mc.sv
// ============================================================================
// tb_conv_kernel_mc : directed self-checking bench for conv_kernel_mc.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_conv_kernel_mc;

  localparam int DATA_W = 8;
  localparam int KK     = 9;
  localparam int N_CH   = 2;
  localparam int OUT_W  = 16;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_first;
  logic                        in_last;
  logic [KK*DATA_W-1:0]        ifmap;
  logic [N_CH*KK*DATA_W-1:0]   weight;
  logic                        cfg_relu;
  logic [4:0]                  cfg_shift;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_CH*OUT_W-1:0]       ofmap;
  logic [N_CH-1:0]             out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_kernel_mc #(
    .DATA_W(DATA_W), .KSIZE(3), .N_CH(N_CH), .ACC_W(32), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .ifmap(ifmap), .weight(weight), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready), .ofmap(ofmap), .out_ovf(out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First n window elements carry a, the rest are 0; ch0/ch1 weights are w0/w1.
  task automatic drive(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1,
                       input int n, input logic first, input logic last);
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    for (int i = 0; i < KK; i++) begin
      ifmap[i*DATA_W +: DATA_W]        = (i < n) ? a : 8'h00;
      weight[i*DATA_W +: DATA_W]       = w0;
      weight[(KK+i)*DATA_W +: DATA_W]  = w1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1,
                      input int n, input logic first, input logic last);
    drive(a, w0, w1, n, first, last);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One-beat group; checks latency then the loaded result.
  task automatic one_beat(input string tag, input logic [7:0] a, input logic [7:0] w0,
                          input logic [7:0] w1, input logic [31:0] exp_of, input logic [1:0] exp_ovf);
    send(a, w0, w1, KK, 1'b1, 1'b1);
    chk({tag, "_lat"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_ofmap"}, ofmap, exp_of);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    ifmap = '0; weight = '0; cfg_relu = 1'b0; cfg_shift = 5'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ofmap", ofmap, 32'h0);
    chk("rst_ovf", out_ovf, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);

    one_beat("ones", 8'd1, 8'd1, 8'd2, 32'h0012_0009, 2'b00);
    @(negedge clk);
    chk("ones_clear", out_valid, 1'b0);

    one_beat("sat_pos", 8'h80, 8'h80, 8'h80, 32'h7FFF_7FFF, 2'b11);
    cfg_shift = 5'd3;
    one_beat("shift3", 8'h80, 8'h80, 8'h80, 32'h4800_4800, 2'b00);
    cfg_shift = 5'd0;
    one_beat("neg", 8'd1, 8'hFF, 8'hFF, 32'hFFF7_FFF7, 2'b00);
    cfg_relu = 1'b1;
    one_beat("relu", 8'd1, 8'hFF, 8'hFF, 32'h0000_0000, 2'b00);
    cfg_relu = 1'b0;
    @(negedge clk);

    // Four-beat group back to back, then a one-beat group of 5.
    send(8'd1, 8'd1, 8'd2, KK, 1'b1, 1'b0);
    send(8'd1, 8'd1, 8'd2, KK, 1'b0, 1'b0);
    send(8'd1, 8'd1, 8'd2, KK, 1'b0, 1'b0);
    send(8'd1, 8'd1, 8'd2, KK, 1'b0, 1'b1);
    send(8'd1, 8'd1, 8'd2, 5,  1'b1, 1'b1);
    chk("grp4_valid", out_valid, 1'b1);
    chk("grp4_ofmap", ofmap, 32'h0048_0024);
    @(negedge clk);
    chk("grp1_valid", out_valid, 1'b1);
    chk("grp1_ofmap", ofmap, 32'h000A_0005);
    @(negedge clk);
    chk("grp_clear", out_valid, 1'b0);

    // Backpressure: result A held while beats B (first) and C (last) queue up.
    out_ready = 1'b0;
    send(8'd1, 8'd1, 8'd1, KK, 1'b1, 1'b1);
    drive(8'd1, 8'd1, 8'd1, 2, 1'b1, 1'b0);
    @(negedge clk);
    drive(8'd1, 8'd1, 8'd1, 3, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ofmap", ofmap, 32'h0009_0009);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    drive(8'd1, 8'd1, 8'd1, 1, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_bc_valid", out_valid, 1'b1);
    chk("bp_bc_ofmap", ofmap, 32'h0005_0005);
    @(negedge clk);
    chk("bp_d_valid", out_valid, 1'b1);
    chk("bp_d_ofmap", ofmap, 32'h0001_0001);
    @(negedge clk);
    chk("bp_clear", out_valid, 1'b0);

    // Reset in the middle of a group drops the partial sum.
    send(8'd1, 8'd1, 8'd1, KK, 1'b1, 1'b0);
    send(8'd1, 8'd1, 8'd1, KK, 1'b0, 1'b0);
    send(8'd1, 8'd1, 8'd1, KK, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ofmap", ofmap, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd1, 8'd1, 8'd1, 2, 1'b0, 1'b1);
    chk("post_rst_lat", out_valid, 1'b0);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_ofmap", ofmap, 32'h0002_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
